serial_subtractor: RTL and testbench

- Bit-serial, multi-cycle WIDTH-bit subtractor: computes diff = a - b - bin one bit per clock, LSB first, using a single full-subtractor cell and a registered borrow.
- Subtract-side counterpart to the arithmetic library's full-adder cell; intended for area-constrained datapaths that trade latency for logic.
- Start/busy/done handshake; results held stable until the next accepted start.

---
 rtl/serial_subtractor.sv | 114 +++++++++++
 tb/tb_serial_subtractor.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial WIDTH-bit subtractor: diff = a - b - bin, one bit per clock, LSB first,
//   built from a single full-subtractor cell and a registered borrow.
//
// Ports
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   start_i   in   request; accepted only in IDLE or DONE
//   a_i       in   minuend, sampled on the accepting edge
//   b_i       in   subtrahend, sampled on the accepting edge
//   bin_i     in   borrow-in, sampled on the accepting edge
//   busy_o    out  high while bits are being processed
//   done_o    out  one-cycle pulse, results newly updated
//   diff_o    out  a - b - bin modulo 2^WIDTH
//   bout_o    out  unsigned borrow-out (a < b + bin)
//   ovf_o     out  two's-complement overflow of the subtraction
module serial_subtractor #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             bin_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] diff_o,
   output logic             bout_o,
   output logic             ovf_o
);

   localparam int unsigned CntW = $clog2(WIDTH);
   localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

   typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

   state_e           state_q;
   logic [WIDTH-1:0] a_q, b_q, res_q;
   logic             br_q;
   logic [CntW-1:0]  cnt_q;
   logic             busy_q, done_q, bout_q, ovf_q;
   logic [WIDTH-1:0] diff_q;

   // Full-subtractor cell on the current LSBs of the operand shift registers.
   logic             d_bit, br_next;
   logic [WIDTH-1:0] res_next;

   always_comb begin
      d_bit    = a_q[0] ^ b_q[0] ^ br_q;
      br_next  = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
      res_next = {d_bit, res_q[WIDTH-1:1]};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         br_q    <= 1'b0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         diff_q  <= '0;
         bout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle, StDone: begin
               done_q <= 1'b0;
               if (start_i) begin
                  a_q     <= a_i;
                  b_q     <= b_i;
                  br_q    <= bin_i;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= StBusy;
               end else begin
                  state_q <= StIdle;
               end
            end
            StBusy: begin
               a_q   <= {1'b0, a_q[WIDTH-1:1]};
               b_q   <= {1'b0, b_q[WIDTH-1:1]};
               br_q  <= br_next;
               res_q <= res_next;
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == LastBit) begin
                  // a_q[0]/b_q[0] hold the operand MSBs on the final bit.
                  diff_q  <= res_next;
                  bout_q  <= br_next;
                  ovf_q   <= (a_q[0] ^ b_q[0]) & (d_bit ^ a_q[0]);
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= StDone;
               end
            end
            default: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign busy_o = busy_q;
   assign done_o = done_q;
   assign diff_o = diff_q;
   assign bout_o = bout_q;
   assign ovf_o  = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Testbench for serial_subtractor: directed vectors on an 8-bit instance plus a
// modest random sweep on 8-bit and 32-bit instances against a reference model.
module tb_serial_subtractor;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic        start8, bin8, busy8, done8, bout8, ovf8;
   logic [7:0]  a8, b8, diff8;
   logic        start32, bin32, busy32, done32, bout32, ovf32;
   logic [31:0] a32, b32, diff32;

   serial_subtractor #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .start_i(start8), .a_i(a8), .b_i(b8), .bin_i(bin8),
      .busy_o(busy8), .done_o(done8), .diff_o(diff8), .bout_o(bout8), .ovf_o(ovf8)
   );

   serial_subtractor #(.WIDTH(32)) dut32 (
      .clk(clk), .rst_n(rst_n), .start_i(start32), .a_i(a32), .b_i(b32), .bin_i(bin32),
      .busy_o(busy32), .done_o(done32), .diff_o(diff32), .bout_o(bout32), .ovf_o(ovf32)
   );

   int tests = 0;
   int errors = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Launch one 8-bit operation from IDLE, wait for done, check results and timing.
   task automatic run8(input logic [7:0] av, input logic [7:0] bv, input logic binv,
                       input logic [7:0] ed, input logic eb, input logic eo, input string tag);
      int lat;
      a8 = av; b8 = bv; bin8 = binv; start8 = 1'b1;
      tick();
      start8 = 1'b0;
      check_eq({tag, ":busy"}, 64'(busy8), 64'd1);
      lat = 0;
      while (!done8 && lat < 40) begin
         tick();
         lat++;
      end
      check_eq({tag, ":lat"}, 64'(lat), 64'd8);
      check_eq({tag, ":diff"}, 64'(diff8), 64'(ed));
      check_eq({tag, ":bout"}, 64'(bout8), 64'(eb));
      check_eq({tag, ":ovf"}, 64'(ovf8), 64'(eo));
      check_eq({tag, ":busy_at_done"}, 64'(busy8), 64'd0);
      tick();
      check_eq({tag, ":done_1cyc"}, 64'(done8), 64'd0);
   endtask

   task automatic run8_rand();
      logic [7:0] av, bv, ed;
      logic       binv, eb, eo;
      av = 8'($urandom); bv = 8'($urandom); binv = 1'($urandom);
      {eb, ed} = {1'b0, av} - {1'b0, bv} - 9'(binv);
      eo = (av[7] ^ bv[7]) & (ed[7] ^ av[7]);
      run8(av, bv, binv, ed, eb, eo, "rand8");
   endtask

   task automatic run32_rand();
      logic [31:0] av, bv, ed;
      logic        binv, eb, eo;
      int          lat;
      av = $urandom; bv = $urandom; binv = 1'($urandom);
      {eb, ed} = {1'b0, av} - {1'b0, bv} - 33'(binv);
      eo = (av[31] ^ bv[31]) & (ed[31] ^ av[31]);
      a32 = av; b32 = bv; bin32 = binv; start32 = 1'b1;
      tick();
      start32 = 1'b0;
      lat = 0;
      while (!done32 && lat < 60) begin
         tick();
         lat++;
      end
      check_eq("rand32:lat", 64'(lat), 64'd32);
      check_eq("rand32:res", {30'd0, eo, eb, ed}, {30'd0, ovf32, bout32, diff32});
      tick();
   endtask

   initial begin
      logic [7:0] op_a [3];
      logic [7:0] op_b [3];
      logic       op_c [3];
      logic [7:0] ex_d [3];
      logic       ex_b [3];
      logic       ex_o [3];
      logic [7:0] prev_diff;
      int         lat;

      rst_n = 1'b0;
      start8 = 0; a8 = 0; b8 = 0; bin8 = 0;
      start32 = 0; a32 = 0; b32 = 0; bin32 = 0;
      #3;
      check_eq("reset:outs8", {busy8, done8, bout8, ovf8, diff8}, 12'h000);
      check_eq("reset:outs32", {busy32, done32, bout32, ovf32, diff32}, 36'h0);
      #19 rst_n = 1'b1;
      tick();

      // Basic and wrap / overflow cases
      run8(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, "t1_5m3");
      run8(8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0, "t2_3m5");
      run8(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, "t2_80m01");
      run8(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, "t2_7Fm FF");
      run8(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, "t3_0m0b1");
      run8(8'hFF, 8'hFE, 1'b1, 8'h00, 1'b0, 1'b0, "t3_FFmFEb1");
      run8(8'h5A, 8'h5A, 1'b1, 8'hFF, 1'b1, 1'b0, "t3_eqb1");

      // start during BUSY and operand changes mid-flight are ignored
      a8 = 8'h10; b8 = 8'h01; bin8 = 1'b0; start8 = 1'b1;
      tick();
      start8 = 1'b0;
      tick(); tick();
      a8 = 8'hAA; b8 = 8'h55; bin8 = 1'b1; start8 = 1'b1;
      tick();
      start8 = 1'b0;
      lat = 3;
      while (!done8 && lat < 40) begin
         tick();
         lat++;
      end
      check_eq("t4:lat", 64'(lat), 64'd8);
      check_eq("t4:res", {bout8, ovf8, diff8}, {2'b00, 8'h0F});
      tick();
      lat = 0;
      for (int i = 0; i < 12; i++) begin
         if (done8 || busy8) lat++;
         tick();
      end
      check_eq("t4:no_extra", 64'(lat), 64'd0);

      // start held high: back-to-back, one result per 9 cycles
      op_a[0] = 8'h20; op_b[0] = 8'h05; op_c[0] = 1'b0;
      ex_d[0] = 8'h1B; ex_b[0] = 1'b0; ex_o[0] = 1'b0;
      op_a[1] = 8'h05; op_b[1] = 8'h20; op_c[1] = 1'b1;
      ex_d[1] = 8'hE4; ex_b[1] = 1'b1; ex_o[1] = 1'b0;
      op_a[2] = 8'h80; op_b[2] = 8'h7F; op_c[2] = 1'b0;
      ex_d[2] = 8'h01; ex_b[2] = 1'b0; ex_o[2] = 1'b1;
      prev_diff = 8'h0F;
      a8 = op_a[0]; b8 = op_b[0]; bin8 = op_c[0]; start8 = 1'b1;
      tick();
      for (int k = 0; k < 3; k++) begin
         check_eq("t5:busy", 64'(busy8), 64'd1);
         if (k < 2) begin
            a8 = op_a[k+1]; b8 = op_b[k+1]; bin8 = op_c[k+1];
         end
         tick(); tick();
         check_eq("t5:hold", 64'(diff8), 64'(prev_diff));
         lat = 2;
         while (!done8 && lat < 40) begin
            tick();
            lat++;
         end
         check_eq("t5:lat", 64'(lat), 64'd8);
         check_eq("t5:res", {bout8, ovf8, diff8}, {ex_b[k], ex_o[k], ex_d[k]});
         prev_diff = ex_d[k];
         if (k == 2) start8 = 1'b0;
         tick();
      end
      check_eq("t5:idle", {busy8, done8}, 2'b00);

      // Asynchronous reset mid-operation
      a8 = 8'h40; b8 = 8'h01; bin8 = 1'b0; start8 = 1'b1;
      tick();
      start8 = 1'b0;
      tick(); tick(); tick();
      #1 rst_n = 1'b0;
      #1;
      check_eq("t6:async", {busy8, done8, bout8, ovf8, diff8}, 12'h000);
      #10 rst_n = 1'b1;
      lat = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (done8 || busy8) lat++;
      end
      check_eq("t6:quiet", 64'(lat), 64'd0);
      run8(8'hC8, 8'h64, 1'b0, 8'h64, 1'b0, 1'b1, "t6_fresh");

      // Random sweep
      fork
         for (int i = 0; i < 400; i++) run8_rand();
         for (int i = 0; i < 150; i++) run32_rand();
      join

      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule
